// File: rtl/sobel_window_scheduler_if.sv
// Handshake bundle between the Sobel window scheduler, pixel memory and the
// Sobel kernel.
//   mem_*  : pixel read channel (req/row/col out of scheduler, ack/data back)
//   win_*  : assembled 3x3 window channel (valid/row/col/data out, ready back)
// master = scheduler side, slave = memory/kernel side.
interface sobel_window_scheduler_if #(
  parameter int AW = 8,
  parameter int DW = 8
);
  logic            mem_req;
  logic [AW-1:0]   mem_row;
  logic [AW-1:0]   mem_col;
  logic            mem_ack;
  logic [DW-1:0]   mem_data;
  logic            win_valid;
  logic            win_ready;
  logic [AW-1:0]   win_row;
  logic [AW-1:0]   win_col;
  logic [9*DW-1:0] win_data;

  modport master (
    output mem_req, mem_row, mem_col,
    input  mem_ack, mem_data,
    output win_valid, win_row, win_col, win_data,
    input  win_ready
  );

  modport slave (
    input  mem_req, mem_row, mem_col,
    output mem_ack, mem_data,
    input  win_valid, win_row, win_col, win_data,
    output win_ready
  );
endinterface

// File: rtl/sobel_window_scheduler.sv
// Raster-scan controller for the Sobel stage. Visits every pixel of an
// IMG_H x IMG_W frame in row-major order, gathers its 3x3 neighbourhood one
// tap at a time (zero for taps outside the frame, a memory read otherwise)
// and offers the finished window to the kernel over a valid/ready handshake.
// Ports:
//   clk, rst_n : clock (rising edge), asynchronous active-low reset
//   start      : frame start pulse, only acted on when idle
//   busy       : high whenever not idle
//   done       : single-cycle pulse after the last window is accepted
//   bus        : master side of sobel_window_scheduler_if (mem_* read
//                channel, win_* window channel; tap k at win_data[k*DW +: DW])
module sobel_window_scheduler #(
  parameter int IMG_W = 128,
  parameter int IMG_H = 128,
  parameter int AW    = 8,
  parameter int DW    = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  output logic busy,
  output logic done,
  sobel_window_scheduler_if.master bus
);

  typedef enum logic [2:0] {S_IDLE, S_TAP, S_REQ, S_EMIT, S_DONE} state_t;

  localparam logic [AW-1:0]        LAST_COL = AW'(IMG_W - 1);
  localparam logic [AW-1:0]        LAST_ROW = AW'(IMG_H - 1);
  localparam logic signed [AW+1:0] MAX_NR   = (AW+2)'(IMG_H - 1);
  localparam logic signed [AW+1:0] MAX_NC   = (AW+2)'(IMG_W - 1);
  localparam logic signed [AW+1:0] OFS_M1   = '1;
  localparam logic signed [AW+1:0] OFS_Z    = '0;
  localparam logic signed [AW+1:0] OFS_P1   = (AW+2)'(1);

  state_t          state_q, state_d;
  logic [AW-1:0]   row_q, row_d, col_q, col_d;
  logic [3:0]      k_q, k_d;
  logic [DW-1:0]   tap_q [9];
  logic [DW-1:0]   tap_d [9];
  logic [AW-1:0]   mem_row_q, mem_row_d, mem_col_q, mem_col_d;
  logic            busy_q, busy_d, done_q, done_d;
  logic            mem_req_q, mem_req_d, win_valid_q, win_valid_d;

  logic signed [AW+1:0] dr, dc, nr, nc;
  logic                 padded;

  // Tap k walks the neighbourhood row by row: k/3 selects dr, k%3 selects dc.
  always_comb begin
    unique case (k_q)
      4'd0, 4'd1, 4'd2: dr = OFS_M1;
      4'd3, 4'd4, 4'd5: dr = OFS_Z;
      default:          dr = OFS_P1;
    endcase
    unique case (k_q)
      4'd0, 4'd3, 4'd6: dc = OFS_M1;
      4'd1, 4'd4, 4'd7: dc = OFS_Z;
      default:          dc = OFS_P1;
    endcase
    // Two guard bits keep row-1 at row 0 negative and row+1 at the top
    // coordinate from wrapping back into range.
    nr     = $signed({2'b00, row_q}) + dr;
    nc     = $signed({2'b00, col_q}) + dc;
    padded = nr[AW+1] || nc[AW+1] || (nr > MAX_NR) || (nc > MAX_NC);
  end

  always_comb begin
    state_d   = state_q;
    row_d     = row_q;
    col_d     = col_q;
    k_d       = k_q;
    tap_d     = tap_q;
    mem_row_d = mem_row_q;
    mem_col_d = mem_col_q;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_TAP;
          row_d   = '0;
          col_d   = '0;
          k_d     = '0;
        end
      end
      S_TAP: begin
        if (padded) begin
          tap_d[k_q] = '0;
          if (k_q == 4'd8) state_d = S_EMIT;
          else             k_d     = k_q + 4'd1;
        end else begin
          mem_row_d = nr[AW-1:0];
          mem_col_d = nc[AW-1:0];
          state_d   = S_REQ;
        end
      end
      S_REQ: begin
        if (bus.mem_ack) begin
          tap_d[k_q] = bus.mem_data;
          if (k_q == 4'd8) begin
            state_d = S_EMIT;
          end else begin
            k_d     = k_q + 4'd1;
            state_d = S_TAP;
          end
        end
      end
      S_EMIT: begin
        if (bus.win_ready) begin
          k_d = '0;
          if (col_q != LAST_COL) begin
            col_d   = col_q + 1'b1;
            state_d = S_TAP;
          end else begin
            col_d = '0;
            if (row_q != LAST_ROW) begin
              row_d   = row_q + 1'b1;
              state_d = S_TAP;
            end else begin
              state_d = S_DONE;
            end
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Outputs are registered copies of the next-state decode so they switch
    // together with the state register.
    busy_d      = (state_d != S_IDLE);
    mem_req_d   = (state_d == S_REQ);
    win_valid_d = (state_d == S_EMIT);
    done_d      = (state_d == S_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      row_q       <= '0;
      col_q       <= '0;
      k_q         <= '0;
      mem_row_q   <= '0;
      mem_col_q   <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      mem_req_q   <= 1'b0;
      win_valid_q <= 1'b0;
      for (int i = 0; i < 9; i++) tap_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      row_q       <= row_d;
      col_q       <= col_d;
      k_q         <= k_d;
      mem_row_q   <= mem_row_d;
      mem_col_q   <= mem_col_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      mem_req_q   <= mem_req_d;
      win_valid_q <= win_valid_d;
      for (int i = 0; i < 9; i++) tap_q[i] <= tap_d[i];
    end
  end

  assign busy          = busy_q;
  assign done          = done_q;
  assign bus.mem_req   = mem_req_q;
  assign bus.mem_row   = mem_row_q;
  assign bus.mem_col   = mem_col_q;
  assign bus.win_valid = win_valid_q;
  assign bus.win_row   = row_q;
  assign bus.win_col   = col_q;

  for (genvar g = 0; g < 9; g++) begin : g_pack
    assign bus.win_data[g*DW +: DW] = tap_q[g];
  end

endmodule

// File: tb/tb_sobel_window_scheduler.sv
module tb_sobel_window_scheduler;
  localparam int W = 4, H = 4, AW = 8, DW = 8, NPIX = W * H;
  localparam int BOUND = 4000;

  logic clk = 1'b0, rst_n = 1'b1, start = 1'b0;
  logic busy, done;

  sobel_window_scheduler_if #(.AW(AW), .DW(DW)) bus ();

  sobel_window_scheduler #(.IMG_W(W), .IMG_H(H), .AW(AW), .DW(DW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done), .bus(bus)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_pass = 0;

  // stimulus configuration
  int         ack_mode = 0;      // 0..3 fixed ack wait, 4 random 0..3
  bit         rand_ready = 0, spur_en = 0;
  int         stall_idx = -1, stall_left = 0;
  logic [7:0] salt = 8'h00;

  // scoreboard state
  int          win_idx = 0, hs_cnt = 0, done_cnt = 0;
  logic [71:0] win0, win5;
  bit          in_req = 0, acked_last = 0, expect_valid = 0;
  int          req_cycles = 0, cur_delay = 0;
  logic [7:0]  req_row, req_col;

  task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic fail_now(input string name);
    n_chk++;
    $display("FAIL %s: event did not occur (got none, expected one)", name);
  endtask

  function automatic logic [7:0] pix(input int r, input int c);
    return 8'(r * 16 + c) ^ salt;
  endfunction

  // Expected window: neighbours inside the frame come from memory, others are 0.
  function automatic logic [71:0] model_win(input int idx);
    int r, c, rr, cc;
    logic [71:0] w;
    r = idx / W; c = idx % W; w = '0;
    for (int dr = -1; dr <= 1; dr++)
      for (int dc = -1; dc <= 1; dc++) begin
        rr = r + dr; cc = c + dc;
        if (rr >= 0 && rr < H && cc >= 0 && cc < W)
          w[((dr + 1) * 3 + (dc + 1)) * 8 +: 8] = pix(rr, cc);
      end
    return w;
  endfunction

  function automatic int model_reads();
    int n;
    n = 0;
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++)
        for (int dr = -1; dr <= 1; dr++)
          for (int dc = -1; dc <= 1; dc++)
            if (r + dr >= 0 && r + dr < H && c + dc >= 0 && c + dc < W) n++;
    return n;
  endfunction

  // Memory responder, kernel sink and per-cycle compare against the model.
  initial begin
    int dr, dc;
    bit rdy;
    bus.mem_ack = 1'b0; bus.mem_data = '0; bus.win_ready = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        bus.mem_ack = 1'b0; bus.win_ready = 1'b0;
        in_req = 0; acked_last = 0; expect_valid = 0;
      end else begin
        if (acked_last) begin
          check("req_drop_after_ack", bus.mem_req, 1'b0);
          acked_last = 0; in_req = 0; bus.mem_ack = 1'b0;
        end else if (bus.mem_req) begin
          if (!in_req) begin
            in_req = 1; req_row = bus.mem_row; req_col = bus.mem_col; req_cycles = 0;
            cur_delay = (ack_mode == 4) ? int'($urandom_range(0, 3)) : ack_mode;
            check("addr_in_frame", (req_row < H && req_col < W), 1'b1);
            if (win_idx < NPIX) begin
              dr = int'(req_row) - win_idx / W; dc = int'(req_col) - win_idx % W;
              check("addr_near_centre", (dr >= -1 && dr <= 1 && dc >= -1 && dc <= 1), 1'b1);
            end
          end else begin
            check("mem_row_stable", bus.mem_row, req_row);
            check("mem_col_stable", bus.mem_col, req_col);
          end
          req_cycles++;
          if (req_cycles > cur_delay) begin
            bus.mem_ack = 1'b1; bus.mem_data = pix(req_row, req_col);
            hs_cnt++; acked_last = 1;
          end else begin
            bus.mem_ack = 1'b0; bus.mem_data = 8'($urandom);
          end
        end else begin
          if (in_req) begin
            fail_now("req_held_until_ack");
            in_req = 0;
          end
          // stray acks while no request is outstanding must be ignored
          if (spur_en && $urandom_range(0, 3) == 0) begin
            bus.mem_ack = 1'b1; bus.mem_data = 8'($urandom);
          end else bus.mem_ack = 1'b0;
        end

        if (expect_valid) check("valid_held", bus.win_valid, 1'b1);
        expect_valid = 0;
        if (done) begin
          done_cnt++;
          check("done_after_last", win_idx, NPIX);
          check("busy_in_done", busy, 1'b1);
        end
        if (bus.win_valid) begin
          check("no_req_in_emit", bus.mem_req, 1'b0);
          check("busy_in_emit", busy, 1'b1);
          if (win_idx >= NPIX) begin
            fail_now("no_extra_window");
          end else begin
            check("win_row", bus.win_row, win_idx / W);
            check("win_col", bus.win_col, win_idx % W);
            check("win_data", bus.win_data, model_win(win_idx));
            if (win_idx == 0) win0 = bus.win_data;
            if (win_idx == 5) win5 = bus.win_data;
          end
          if (win_idx == stall_idx && stall_left > 0) begin
            rdy = 0; stall_left--;
          end else if (rand_ready) rdy = ($urandom_range(0, 2) != 0);
          else rdy = 1;
          bus.win_ready = rdy;
          if (rdy) win_idx++;
          else expect_valid = 1;
        end else begin
          bus.win_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b0;
        end
      end
    end
  end

  task automatic clear_counts();
    win_idx = 0; hs_cnt = 0; done_cnt = 0;
  endtask

  task automatic pulse_start();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic wait_done(input string name, input bit restart_in_done);
    int n;
    n = 0;
    while (!done && n < BOUND) begin
      @(negedge clk); n++;
    end
    if (!done) fail_now(name);
    else if (restart_in_done) begin
      start = 1'b1;
      @(negedge clk); start = 1'b0;
    end
    repeat (4) @(negedge clk);
  endtask

  task automatic run_frame(input string name);
    @(negedge clk); clear_counts();
    pulse_start();
    wait_done(name, 0);
    check({name, "_windows"}, win_idx, NPIX);
    check({name, "_reads"}, hs_cnt, model_reads());
    check({name, "_done_pulses"}, done_cnt, 1);
    check({name, "_idle"}, busy, 1'b0);
  endtask

  initial begin
    int n;
    #1 rst_n = 1'b0;
    #13;
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_mem_req", bus.mem_req, 1'b0);
    check("rst_win_valid", bus.win_valid, 1'b0);
    check("rst_win_data", bus.win_data, '0);
    check("rst_mem_row", bus.mem_row, '0);
    check("rst_win_col", bus.win_col, '0);
    @(negedge clk); rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // baseline frame, zero-wait acks, kernel always ready
    run_frame("base");
    check("base_reads_literal", hs_cnt, 100);
    check("base_win00_literal", win0, 72'h111000010000000000);
    check("base_win11_literal", win5, 72'h222120121110020100);

    // kernel back-pressure on window (1,1)
    stall_idx = 5; stall_left = 5;
    run_frame("stall");
    check("stall_consumed", stall_left, 0);
    stall_idx = -1;

    // three-cycle ack wait on every read
    ack_mode = 3;
    run_frame("slow_ack");
    check("slow_ack_win00", win0, 72'h111000010000000000);

    // reset during the read phase of window (2,1)
    ack_mode = 1;
    @(negedge clk); clear_counts();
    pulse_start();
    n = 0;
    while (!(win_idx == 9 && bus.mem_req) && n < BOUND) begin
      @(negedge clk); n++;
    end
    if (!(win_idx == 9 && bus.mem_req)) fail_now("reach_window_21");
    #2 rst_n = 1'b0;
    #1;
    check("abort_mem_req", bus.mem_req, 1'b0);
    check("abort_busy", busy, 1'b0);
    check("abort_win_valid", bus.win_valid, 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    ack_mode = 0;
    run_frame("after_abort");
    check("after_abort_win00", win0, 72'h111000010000000000);

    // start while busy and in the DONE cycle must both be ignored
    @(negedge clk); clear_counts();
    pulse_start();
    repeat (30) @(negedge clk);
    pulse_start();
    wait_done("ignore_start", 1);
    repeat (40) @(negedge clk);
    check("ignore_start_done_pulses", done_cnt, 1);
    check("ignore_start_windows", win_idx, NPIX);
    check("ignore_start_idle", busy, 1'b0);
    check("ignore_start_reads", hs_cnt, 100);

    // randomized ack waits, stray acks, ready gaps and pixel contents
    ack_mode = 4; rand_ready = 1; spur_en = 1;
    for (int f = 0; f < 3; f++) begin
      salt = 8'($urandom);
      run_frame("random");
    end
    rand_ready = 0; spur_en = 0;
    repeat (4) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
